// File: rtl/reg_file_mp_if.sv
// Register-file access bundle: read ports, sized write port, scoreboard claim
// and the busy vector.
interface reg_file_mp_if #(
  parameter int XLEN  = 64,
  parameter int NREGS = 32,
  parameter int AW    = 5,
  parameter int NRD   = 3
);
  logic [NRD-1:0]      rd_en;
  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;
  logic                wr_en;
  logic [AW-1:0]       wr_addr;
  logic [XLEN-1:0]     wr_data;
  logic [1:0]          wr_size;
  logic                wr_sext;
  logic                claim_en;
  logic [AW-1:0]       claim_addr;
  logic [NREGS-1:0]    busy;

  modport master (
    output rd_en, rd_addr, wr_en, wr_addr, wr_data, wr_size, wr_sext,
           claim_en, claim_addr,
    input  rd_data, rd_busy, busy
  );

  modport slave (
    input  rd_en, rd_addr, wr_en, wr_addr, wr_data, wr_size, wr_sext,
           claim_en, claim_addr,
    output rd_data, rd_busy, busy
  );
endinterface

// File: rtl/reg_file_mp.sv
// Multi-port register file with sized/extended writes, write-to-read bypass
// and a per-register pending-write scoreboard.
module reg_file_mp #(
  parameter int XLEN    = 64,
  parameter int NREGS   = 32,
  parameter int AW      = 5,
  parameter int NRD     = 3,
  parameter bit ZERO_R0 = 1'b0
) (
  input  logic          clk,
  input  logic          rst_n,
  reg_file_mp_if.slave  bus
);

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_nxt;
  logic [XLEN-1:0]  rd_q   [NRD];
  logic [NRD-1:0]   rd_busy_q;
  logic [XLEN-1:0]  rd_val [NRD];
  logic [NRD-1:0]   rd_bsy;
  logic [AW-1:0]    rd_a   [NRD];
  logic [XLEN-1:0]  wfmt;
  logic             wr_ok;
  logic             cl_ok;

  // Addresses beyond the implemented registers, and r0 in hardwired-zero
  // mode, behave as a sink: writes/claims vanish, reads return zero.
  function automatic logic addr_ok(input logic [AW-1:0] a);
    logic in_range;
    in_range = ({{(32-AW){1'b0}}, a} < 32'(NREGS));
    return in_range && !(ZERO_R0 && (a == '0));
  endfunction

  // Keep the low 8/16/32/XLEN bits and fill the rest with zero or the
  // field's top bit. A doubleword on a 32-bit file is simply the full word.
  function automatic logic [XLEN-1:0] fmt(input logic [XLEN-1:0] d,
                                          input logic [1:0] size,
                                          input logic sext);
    int              w;
    logic [XLEN-1:0] mask;
    logic [XLEN-1:0] r;
    case (size)
      2'd0:    w = 8;
      2'd1:    w = 16;
      2'd2:    w = 32;
      default: w = XLEN;
    endcase
    if (w >= XLEN) mask = '1;
    else           mask = (XLEN'(1) << w) - XLEN'(1);
    r = d & mask;
    if (sext && d[w-1]) r = r | ~mask;
    return r;
  endfunction

  assign wfmt  = fmt(bus.wr_data, bus.wr_size, bus.wr_sext);
  assign wr_ok = bus.wr_en && addr_ok(bus.wr_addr);
  assign cl_ok = bus.claim_en && addr_ok(bus.claim_addr);

  // Next scoreboard: a write retires its pending bit, a same-cycle claim wins.
  always_comb begin
    busy_nxt = busy_q;
    if (wr_ok) busy_nxt[bus.wr_addr] = 1'b0;
    if (cl_ok) busy_nxt[bus.claim_addr] = 1'b1;
  end

  // Per-port read selection with write bypass and post-edge busy.
  always_comb begin
    for (int i = 0; i < NRD; i++) begin
      rd_a[i]   = bus.rd_addr[i*AW +: AW];
      rd_val[i] = '0;
      rd_bsy[i] = 1'b0;
      if (addr_ok(rd_a[i])) begin
        rd_val[i] = (wr_ok && (bus.wr_addr == rd_a[i])) ? wfmt : regs[rd_a[i]];
        rd_bsy[i] = busy_nxt[rd_a[i]];
      end
    end
  end

  // Register array storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREGS; r++) regs[r] <= '0;
    end else if (wr_ok) begin
      regs[bus.wr_addr] <= wfmt;
    end
  end

  // Scoreboard register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_nxt;
  end

  // Read-port capture; a disabled port holds its last data and busy bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NRD; i++) rd_q[i] <= '0;
      rd_busy_q <= '0;
    end else begin
      for (int i = 0; i < NRD; i++) begin
        if (bus.rd_en[i]) begin
          rd_q[i]      <= rd_val[i];
          rd_busy_q[i] <= rd_bsy[i];
        end
      end
    end
  end

  for (genvar g = 0; g < NRD; g++) begin : g_rd
    assign bus.rd_data[g*XLEN +: XLEN] = rd_q[g];
  end
  assign bus.rd_busy = rd_busy_q;
  assign bus.busy    = busy_q;

endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: two instances (ordinary r0 and hardwired-zero r0)
// share one stimulus stream and are compared against a register-array model.
module tb_reg_file_mp;
  localparam int XLEN  = 64;
  localparam int NREGS = 24;
  localparam int AW    = 5;
  localparam int NRD   = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NRD-1:0]    rd_en      = '0;
  logic [NRD*AW-1:0] rd_addr    = '0;
  logic              wr_en      = 1'b0;
  logic [AW-1:0]     wr_addr    = '0;
  logic [XLEN-1:0]   wr_data    = '0;
  logic [1:0]        wr_size    = '0;
  logic              wr_sext    = 1'b0;
  logic              claim_en   = 1'b0;
  logic [AW-1:0]     claim_addr = '0;

  reg_file_mp_if #(.XLEN(XLEN), .NREGS(NREGS), .AW(AW), .NRD(NRD)) if0 ();
  reg_file_mp_if #(.XLEN(XLEN), .NREGS(NREGS), .AW(AW), .NRD(NRD)) if1 ();

  assign if0.rd_en = rd_en;       assign if1.rd_en = rd_en;
  assign if0.rd_addr = rd_addr;   assign if1.rd_addr = rd_addr;
  assign if0.wr_en = wr_en;       assign if1.wr_en = wr_en;
  assign if0.wr_addr = wr_addr;   assign if1.wr_addr = wr_addr;
  assign if0.wr_data = wr_data;   assign if1.wr_data = wr_data;
  assign if0.wr_size = wr_size;   assign if1.wr_size = wr_size;
  assign if0.wr_sext = wr_sext;   assign if1.wr_sext = wr_sext;
  assign if0.claim_en = claim_en; assign if1.claim_en = claim_en;
  assign if0.claim_addr = claim_addr; assign if1.claim_addr = claim_addr;

  reg_file_mp #(.XLEN(XLEN), .NREGS(NREGS), .AW(AW), .NRD(NRD), .ZERO_R0(1'b0))
    dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
  reg_file_mp #(.XLEN(XLEN), .NREGS(NREGS), .AW(AW), .NRD(NRD), .ZERO_R0(1'b1))
    dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));

  logic [NRD*XLEN-1:0] rdd [2];
  logic [NRD-1:0]      rdb [2];
  logic [NREGS-1:0]    bsy [2];
  assign rdd[0] = if0.rd_data; assign rdd[1] = if1.rd_data;
  assign rdb[0] = if0.rd_busy; assign rdb[1] = if1.rd_busy;
  assign bsy[0] = if0.busy;    assign bsy[1] = if1.busy;

  // Model state: [z] selects ordinary (0) or hardwired-zero (1) r0.
  logic [63:0] m_reg  [2][NREGS];
  bit          m_busy [2][NREGS];
  logic [63:0] m_rd   [2][NRD];
  bit          m_rb   [2][NRD];

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit m_valid(input int a, input int z);
    return (a < NREGS) && !(z == 1 && a == 0);
  endfunction

  function automatic logic [63:0] m_fmt(input logic [63:0] d, input logic [1:0] s,
                                        input logic x);
    int sh;
    sh = 64 - ((s == 2'd0) ? 8 : (s == 2'd1) ? 16 : (s == 2'd2) ? 32 : 64);
    if (x) return 64'($signed(d << sh) >>> sh);
    return (d << sh) >> sh;
  endfunction

  task automatic model_clear();
    for (int z = 0; z < 2; z++) begin
      for (int r = 0; r < NREGS; r++) begin m_reg[z][r] = '0; m_busy[z][r] = 0; end
      for (int i = 0; i < NRD; i++) begin m_rd[z][i] = '0; m_rb[z][i] = 0; end
    end
  endtask

  // One clock edge of architectural behaviour: update state, then reads see it.
  task automatic model_step();
    int a;
    if (!rst_n) begin model_clear(); return; end
    for (int z = 0; z < 2; z++) begin
      if (wr_en && m_valid(int'(wr_addr), z)) begin
        m_reg[z][wr_addr]  = m_fmt(wr_data, wr_size, wr_sext);
        m_busy[z][wr_addr] = 0;
      end
      if (claim_en && m_valid(int'(claim_addr), z)) m_busy[z][claim_addr] = 1;
      for (int i = 0; i < NRD; i++) begin
        if (rd_en[i]) begin
          a = int'(rd_addr[i*AW +: AW]);
          if (m_valid(a, z)) begin m_rd[z][i] = m_reg[z][a]; m_rb[z][i] = m_busy[z][a]; end
          else               begin m_rd[z][i] = '0;          m_rb[z][i] = 0; end
        end
      end
    end
  endtask

  task automatic check_all();
    logic [63:0] eb;
    for (int z = 0; z < 2; z++) begin
      for (int i = 0; i < NRD; i++)
        chk($sformatf("rd_data z%0d p%0d", z, i), rdd[z][i*XLEN +: XLEN], m_rd[z][i]);
      eb = '0;
      for (int i = 0; i < NRD; i++) eb[i] = m_rb[z][i];
      chk($sformatf("rd_busy z%0d", z), 64'(rdb[z]), eb);
      eb = '0;
      for (int r = 0; r < NREGS; r++) eb[r] = m_busy[z][r];
      chk($sformatf("busy z%0d", z), 64'(bsy[z]), eb);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic idle();
    rd_en = '0; wr_en = 1'b0; claim_en = 1'b0;
  endtask

  task automatic set_wr(input int a, input logic [63:0] d, input logic [1:0] s, input logic x);
    wr_en = 1'b1; wr_addr = AW'(a); wr_data = d; wr_size = s; wr_sext = x;
  endtask

  task automatic set_rd(input int p, input int a);
    rd_en[p] = 1'b1; rd_addr[p*AW +: AW] = AW'(a);
  endtask

  task automatic set_cl(input int a);
    claim_en = 1'b1; claim_addr = AW'(a);
  endtask

  task automatic chk_zero_outputs(input string tag);
    for (int z = 0; z < 2; z++) begin
      chk({tag, " rd_data"}, 64'(rdd[z][XLEN-1:0]) | 64'(rdd[z][2*XLEN-1:XLEN]) |
          64'(rdd[z][3*XLEN-1:2*XLEN]), 64'd0);
      chk({tag, " rd_busy"}, 64'(rdb[z]), 64'd0);
      chk({tag, " busy"}, 64'(bsy[z]), 64'd0);
    end
  endtask

  initial begin
    model_clear();
    #1;
    chk_zero_outputs("reset");
    #1 rst_n = 1'b1;

    // Size and extension on r5.
    idle(); set_wr(5, 64'h80F0, 2'd0, 1'b1); cycle();
    idle(); set_rd(0, 5); cycle();
    chk("byte sext", rdd[0][63:0], 64'hFFFF_FFFF_FFFF_FFF0);
    idle(); set_wr(5, 64'h80F0, 2'd0, 1'b0); cycle();
    idle(); set_rd(0, 5); cycle();
    chk("byte zext", rdd[0][63:0], 64'h0000_0000_0000_00F0);
    idle(); set_wr(5, 64'h80F0, 2'd1, 1'b1); set_rd(1, 5); cycle();
    chk("half sext bypass", rdd[0][127:64], 64'hFFFF_FFFF_FFFF_80F0);
    idle(); set_wr(5, 64'h1234_5678_9ABC_DEF0, 2'd2, 1'b1); set_rd(2, 5); cycle();
    chk("word sext", rdd[0][191:128], 64'hFFFF_FFFF_9ABC_DEF0);

    // Same-cycle write and read on all ports.
    idle(); set_wr(7, 64'h1234, 2'd3, 1'b0);
    set_rd(0, 7); set_rd(1, 7); set_rd(2, 7); cycle();
    for (int i = 0; i < NRD; i++) chk($sformatf("bypass p%0d", i), rdd[0][i*XLEN +: XLEN], 64'h1234);

    // Scoreboard on r3.
    idle(); set_cl(3); cycle();
    idle(); set_rd(0, 3); cycle();
    chk("claim rd_busy", 64'(rdb[0][0]), 64'd1);
    chk("claim busy3", 64'(bsy[0][3]), 64'd1);
    idle(); set_wr(3, 64'hAA, 2'd3, 1'b0); cycle();
    chk("write clears busy3", 64'(bsy[0][3]), 64'd0);
    idle(); set_wr(3, 64'hBB, 2'd3, 1'b0); set_cl(3); set_rd(0, 3); cycle();
    chk("claim+write busy3", 64'(bsy[0][3]), 64'd1);
    chk("claim+write rd_busy", 64'(rdb[0][0]), 64'd1);
    chk("claim+write data", rdd[0][63:0], 64'hBB);

    // r0 in both modes.
    idle(); set_wr(0, 64'hFFFF, 2'd3, 1'b0); cycle();
    idle(); set_cl(0); cycle();
    idle(); set_rd(0, 0); cycle();
    chk("zr0 data", rdd[1][63:0], 64'd0);
    chk("zr0 rd_busy", 64'(rdb[1][0]), 64'd0);
    chk("zr0 busy0", 64'(bsy[1][0]), 64'd0);
    chk("r0 data", rdd[0][63:0], 64'hFFFF);
    chk("r0 busy0 claimed", 64'(bsy[0][0]), 64'd1);
    idle(); set_wr(0, 64'hFFFF, 2'd3, 1'b0); cycle();
    chk("r0 busy0 cleared", 64'(bsy[0][0]), 64'd0);

    // Out-of-range addresses.
    idle(); set_wr(30, 64'hDEAD, 2'd3, 1'b0); set_cl(25); set_rd(0, 30); cycle();
    chk("oor read", rdd[0][63:0], 64'd0);
    chk("oor rd_busy", 64'(rdb[0][0]), 64'd0);

    // Read hold.
    idle(); set_wr(1, 64'h55, 2'd3, 1'b0); cycle();
    idle(); set_rd(0, 1); cycle();
    idle(); set_wr(1, 64'h66, 2'd3, 1'b0); rd_addr[AW-1:0] = AW'(1); cycle();
    chk("hold a", rdd[0][63:0], 64'h55);
    idle(); cycle();
    chk("hold b", rdd[0][63:0], 64'h55);
    idle(); set_rd(0, 1); cycle();
    chk("hold release", rdd[0][63:0], 64'h66);

    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      idle();
      if ($urandom_range(0, 3) != 0)
        set_wr(($urandom_range(0, 5) == 0) ? $urandom_range(24, 31) : $urandom_range(0, 7),
               {$urandom, $urandom}, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) == 0)
        set_cl(($urandom_range(0, 5) == 0) ? $urandom_range(24, 31) : $urandom_range(0, 7));
      for (int p = 0; p < NRD; p++)
        if ($urandom_range(0, 3) != 0)
          set_rd(p, ($urandom_range(0, 7) == 0) ? $urandom_range(24, 31) : $urandom_range(0, 7));
      cycle();
    end

    // Reset in the middle of activity.
    for (int r = 1; r <= 4; r++) begin idle(); set_wr(r, 64'h100 + 64'(r), 2'd3, 1'b0); cycle(); end
    idle(); set_cl(2); cycle();
    idle(); set_rd(0, 1); set_rd(1, 2); set_rd(2, 3); cycle();
    chk("pre-reset busy2", 64'(bsy[0][2]), 64'd1);
    chk("pre-reset data", rdd[0][63:0], 64'h101);
    #2 rst_n = 1'b0;
    set_wr(4, 64'h77, 2'd3, 1'b0); set_cl(1);
    #1;
    chk_zero_outputs("async reset");
    model_clear();
    cycle();
    #2 rst_n = 1'b1;
    idle(); set_rd(0, 1); set_rd(1, 2); set_rd(2, 3); cycle();
    for (int i = 0; i < NRD; i++) chk($sformatf("post-reset r%0d", i + 1), rdd[0][i*XLEN +: XLEN], 64'd0);
    idle(); set_rd(0, 4); cycle();
    chk("post-reset r4", rdd[0][63:0], 64'd0);
    chk("post-reset busy", 64'(bsy[0]), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/reg_file_mp.md
REG_FILE_MP -- requirements
Module: reg_file_mp

Interface
REQ-001 Parameter XLEN, default 64, register data width in bits; legal values 32 or 64.
REQ-002 Parameter NREGS, default 32, number of architectural registers.
REQ-003 Parameter AW, default 5, register address width; NREGS SHALL be <= 2^AW.
REQ-004 Parameter NRD, default 3, number of independent read ports.
REQ-005 Parameter ZERO_R0, default 0, 1 = register 0 hardwired to zero (MIPS mode); 0 = register 0 is ordinary (uPower mode).
REQ-006 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-007 rst_n  in  1  asynchronous, active-low reset.
REQ-008 rd_en  in  NRD  per-port read enable.
REQ-009 rd_addr  in  NRD*AW  packed read addresses; port i uses bits [i*AW +: AW].
REQ-010 rd_data  out  NRD*XLEN  packed registered read data; port i uses bits [i*XLEN +: XLEN].
REQ-011 rd_busy  out  NRD  per-port registered scoreboard bit for the address read.
REQ-012 wr_en  in  1  write enable.
REQ-013 wr_addr  in  AW  write address.
REQ-014 wr_data  in  XLEN  raw write data.
REQ-015 wr_size  in  2  write size: 0 byte, 1 halfword, 2 word, 3 doubleword.
REQ-016 wr_sext  in  1  1 = sign-extend the sized value, 0 = zero-extend.
REQ-017 claim_en  in  1  marks claim_addr as having a write pending.
REQ-018 claim_addr  in  AW  register being claimed.
REQ-019 busy  out  NREGS  current scoreboard vector, one bit per register.

Function
REQ-020 Write data SHALL be formatted before storage: the low 8/16/32/XLEN bits of wr_data per wr_size, upper bits filled with the top bit of the sized field if wr_sext=1, else zero.
REQ-021 When XLEN=32, wr_size=3 SHALL behave as wr_size=2.
REQ-022 With wr_en=1 on a rising edge, the formatted value SHALL be stored in register wr_addr.
REQ-023 Writes with wr_addr >= NREGS, or wr_addr=0 when ZERO_R0=1, SHALL be discarded with no state change.
REQ-024 Read latency SHALL be one cycle: on each edge with rd_en[i]=1, rd_data port i SHALL capture register rd_addr[i]; with rd_en[i]=0, port i data and rd_busy[i] SHALL hold.
REQ-025 Write-read bypass: if in the same cycle wr_en=1 and a stored write targets rd_addr[i], port i SHALL capture the newly formatted value, never the stale one.
REQ-026 Reads of addresses >= NREGS, or of address 0 when ZERO_R0=1, SHALL return zero with rd_busy[i]=0.
REQ-027 All NRD ports SHALL operate independently; identical addresses on several ports SHALL return identical data.
REQ-028 Scoreboard: claim_en=1 SHALL set busy[claim_addr] on the edge; a stored write SHALL clear busy[wr_addr].
REQ-029 Claim and write to the same address in the same cycle: busy SHALL end set (the new claim wins) while the data is still written.
REQ-030 Claims to addresses >= NREGS, or to 0 when ZERO_R0=1, SHALL be ignored.
REQ-031 rd_busy[i] SHALL reflect the post-edge busy value of the address captured, consistent with REQ-025 and REQ-029.
REQ-032 A read-to-read, write-to-write, or claim-to-claim throughput of one operation per cycle SHALL be sustained with no stalls.

Reset
REQ-033 While rst_n=0, all registers, busy, rd_data and rd_busy SHALL be zero immediately, independent of clk.
REQ-034 Write, claim and read operations presented while rst_n=0 SHALL be lost.
REQ-035 The first edge after rst_n rises SHALL perform normal operation.

Verification
REQ-036 Size/extension: write wr_data=0x00000000_0000_80F0 with size 0, sext 1 to r5, then read r5 -> 0xFFFF_FFFF_FFFF_FFF0; with sext 0 -> 0x0000_0000_0000_00F0; with size 1, sext 1 -> 0xFFFF_FFFF_FFFF_80F0.
REQ-037 Bypass: same cycle write r7=0x1234 and read r7 on all three ports -> next cycle all ports show 0x1234.
REQ-038 Scoreboard: claim r3, then read r3 -> rd_busy=1, busy[3]=1; write r3=0xAA -> busy[3]=0; claim and write r3 together -> busy[3]=1, r3=the new value.
REQ-039 ZERO_R0=1: write r0=0xFFFF, claim r0, read r0 -> data 0, rd_busy 0, busy[0]=0; repeat with ZERO_R0=0 -> data 0xFFFF, busy[0] cleared by the write.
REQ-040 Reset mid-operation: fill r1..r4 with nonzero values, claim r2, assert rst_n=0 between edges -> busy, rd_data and rd_busy become 0 before the next edge; after release, reads of r1..r4 return 0.
REQ-041 Read hold: read r1=0x55, then drop rd_en[0] and write r1=0x66 -> port 0 stays 0x55 until rd_en[0] is reasserted.
